// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for the line-follower video path. It scans
//   H_TOTAL x V_TOTAL positions and, one register stage later, presents the
//   position together with sync, blanking and frame/line strobes. All outputs
//   come from one register stage, so they always describe the same pixel.
//
// Ports:
//   clock         in   pixel clock, all logic on rising edge
//   reset_n       in   asynchronous active-low reset
//   pixel_row     out  [11:0] current line, 0..V_TOTAL-1 (not clamped)
//   pixel_column  out  [11:0] current pixel, 0..H_TOTAL-1 (not clamped)
//   video_on      out  high inside the visible area
//   horiz_sync    out  horizontal sync, asserted level = SYNC_ACTIVE
//   vert_sync     out  vertical sync, asserted level = SYNC_ACTIVE
//   frame_start   out  one-clock pulse while position (0,0) is presented
//   line_start    out  one-clock pulse while column 0 is presented
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE   = 1024,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 136,
  parameter int unsigned H_BP        = 160,
  parameter int unsigned V_VISIBLE   = 768,
  parameter int unsigned V_FP        = 3,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BP        = 29,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [11:0] pixel_row,
  output logic [11:0] pixel_column,
  output logic        video_on,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS      = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
  localparam logic [11:0] HS_FIRST   = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_LAST    = 12'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST   = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_LAST    = 12'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Scan counters
  logic [11:0] r_h_count;
  logic [11:0] r_v_count;

  // Registered outputs
  logic [11:0] r_pixel_row;
  logic [11:0] r_pixel_column;
  logic        r_video_on;
  logic        r_horiz_sync;
  logic        r_vert_sync;
  logic        r_frame_start;
  logic        r_line_start;

  // Decode of the current (pre-increment) counter values
  logic w_h_last;
  logic w_v_last;
  logic w_video_on;
  logic w_hs_active;
  logic w_vs_active;
  logic w_line_start;
  logic w_frame_start;

  always_comb begin
    w_h_last      = (r_h_count == H_LAST);
    w_v_last      = (r_v_count == V_LAST);
    w_video_on    = (r_h_count < H_VIS) && (r_v_count < V_VIS);
    w_hs_active   = (r_h_count >= HS_FIRST) && (r_h_count <= HS_LAST);
    // Depends on the row only, so in the output stream it changes exactly
    // when column 0 of the new line is presented.
    w_vs_active   = (r_v_count >= VS_FIRST) && (r_v_count <= VS_LAST);
    w_line_start  = (r_h_count == '0);
    w_frame_start = w_line_start && (r_v_count == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_h_last) begin
      r_h_count <= '0;
      r_v_count <= w_v_last ? '0 : r_v_count + 12'd1;
    end else begin
      r_h_count <= r_h_count + 12'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel_row    <= '0;
      r_pixel_column <= '0;
      r_video_on     <= 1'b0;
      r_horiz_sync   <= ~SYNC_ACTIVE;
      r_vert_sync    <= ~SYNC_ACTIVE;
      r_frame_start  <= 1'b0;
      r_line_start   <= 1'b0;
    end else begin
      r_pixel_row    <= r_v_count;
      r_pixel_column <= r_h_count;
      r_video_on     <= w_video_on;
      r_horiz_sync   <= w_hs_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vert_sync    <= w_vs_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_frame_start  <= w_frame_start;
      r_line_start   <= w_line_start;
    end
  end

  assign pixel_row    = r_pixel_row;
  assign pixel_column = r_pixel_column;
  assign video_on     = r_video_on;
  assign horiz_sync   = r_horiz_sync;
  assign vert_sync    = r_vert_sync;
  assign frame_start  = r_frame_start;
  assign line_start   = r_line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen on a reduced raster so several whole
//   frames fit in a short run. The reference model treats the frame as a
//   linear pixel index and derives row/column/sync with division and ranges.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int unsigned HV  = 40;
  localparam int unsigned HFP = 4;
  localparam int unsigned HSY = 6;
  localparam int unsigned HBP = 8;
  localparam int unsigned VV  = 20;
  localparam int unsigned VFP = 2;
  localparam int unsigned VSY = 3;
  localparam int unsigned VBP = 4;
  localparam logic        SA  = 1'b0;

  localparam int unsigned HT    = HV + HFP + HSY + HBP;   // 58
  localparam int unsigned VT    = VV + VFP + VSY + VBP;   // 29
  localparam int unsigned FRAME = HT * VT;                // 1682
  localparam int unsigned NCYC  = 6000;
  localparam int unsigned MID_POS = 15 * HT + 30;

  typedef struct packed {
    logic [11:0] row;
    logic [11:0] col;
    logic        vid;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        ls;
  } out_t;

  logic        clock;
  logic        reset_n;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic        video_on;
  logic        horiz_sync;
  logic        vert_sync;
  logic        frame_start;
  logic        line_start;

  int unsigned vectors;
  int unsigned miscompares;
  out_t        exp_q[$];

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pixel_row(pixel_row),
    .pixel_column(pixel_column),
    .video_on(video_on),
    .horiz_sync(horiz_sync),
    .vert_sync(vert_sync),
    .frame_start(frame_start),
    .line_start(line_start)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic out_t rst_vec();
    out_t o;
    o = '0;
    o.hs = ~SA;
    o.vs = ~SA;
    return o;
  endfunction

  function automatic out_t present(int unsigned p);
    out_t o;
    int unsigned r;
    int unsigned c;
    r = p / HT;
    c = p % HT;
    o.row = 12'(r);
    o.col = 12'(c);
    o.vid = (c < HV) && (r < VV);
    o.hs  = (c >= HV + HFP && c < HV + HFP + HSY) ? SA : ~SA;
    o.vs  = (r >= VV + VFP && r < VV + VFP + VSY) ? SA : ~SA;
    o.fs  = (p == 0);
    o.ls  = (c == 0);
    return o;
  endfunction

  // Stimulus + model: reset_n changes on the falling edge. Each half cycle
  // yields one expectation: the falling-edge sample (shows asynchronous reset
  // with no rising edge in between) and the following rising-edge sample.
  initial begin
    int unsigned pos;
    int unsigned rst_left;
    bit          mid_done;
    out_t        last;
    vectors     = 0;
    miscompares = 0;
    pos         = 0;
    rst_left    = 0;
    mid_done    = 0;
    reset_n     = 1'b0;
    last        = rst_vec();
    repeat (10) begin
      @(negedge clock);
      reset_n = 1'b0;
      exp_q.push_back(rst_vec());
      exp_q.push_back(rst_vec());
    end
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clock);
      if (rst_left == 0) begin
        if (!mid_done && pos == MID_POS) begin
          rst_left = 2;
          mid_done = 1;
        end else if (i > 4000 && $urandom_range(0, 1499) == 0) begin
          rst_left = $urandom_range(1, 3);
        end
      end
      if (rst_left > 0) begin
        reset_n = 1'b0;
        rst_left--;
        pos  = 0;
        last = rst_vec();
        exp_q.push_back(last);
        exp_q.push_back(last);
      end else begin
        reset_n = 1'b1;
        exp_q.push_back(last);
        last = present(pos);
        exp_q.push_back(last);
        pos = (pos + 1) % FRAME;
      end
    end
    @(posedge clock);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic check(input string name);
    out_t act;
    out_t exp;
    act = '{pixel_row, pixel_column, video_on, horiz_sync, vert_sync,
            frame_start, line_start};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: no expectation queued, got row=%0d col=%0d", name,
               act.row, act.col);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s @%0t: got row=%0d col=%0d vid=%b hs=%b vs=%b fs=%b ls=%b, expected row=%0d col=%0d vid=%b hs=%b vs=%b fs=%b ls=%b",
                 name, $time, act.row, act.col, act.vid, act.hs, act.vs, act.fs, act.ls,
                 exp.row, exp.col, exp.vid, exp.hs, exp.vs, exp.fs, exp.ls);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each edge, pops and compares; also
  // checks frame_start spacing across undisturbed frames.
  initial begin
    int unsigned since;
    bit          have;
    since = 0;
    have  = 0;
    forever begin
      @(negedge clock);
      #1;
      check("fall_sample");
      @(posedge clock);
      #1;
      check("rise_sample");
      since++;
      if (!reset_n) begin
        have = 0;
      end else if (frame_start) begin
        if (have) begin
          vectors++;
          if (since != FRAME) begin
            miscompares++;
            $display("FAIL frame_period: got %0d clocks, expected %0d", since, FRAME);
          end
        end
        since = 0;
        have  = 1;
      end
    end
  end

endmodule
